shift_pattern_ctrl: RTL and testbench
=====================================

Name: shift_pattern_ctrl

Overview:
- Sequencer driving the serial input and shift-enable of a BITS-wide LED shift register datapath.
- Accepts a command (mode plus optional parallel pattern) over a valid/ready handshake.
- Generates a slow step strobe from a prescaler and emits the serial bit for each step.
- Supports three modes: walking one, fill/drain and one-shot pattern load.

Parameters:
- BITS, 8, width of the driven shift register; legal range ≥2.
- TICK_DIV, 50000000, clk cycles per step; legal range ≥2.
- DIV_W, 26, prescaler counter width; must satisfy 2^DIV_W ≥ TICK_DIV.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_mode  in  2  00 walk-one, 01 fill/drain, 10 pattern load, 11 no-op.
- cmd_pat  in  BITS  pattern for mode 10; sent MSB first.
- stop  in  1  abort a running command.
- step  out  1  one-cycle shift-enable strobe to the datapath.
- d  out  1  serial bit; valid whenever step=1.
- busy  out  1  command running.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - All registers clear.
  - State IDLE.
  - step=0, d=0, busy=0, done=0, cmd_ready=1.
- States:
  - IDLE -> RUN on accept of mode 00/01/10.
  - IDLE -> DONE on accept of mode 11.
  - RUN -> DONE on the last step of mode 10.
  - RUN -> IDLE on stop.
  - DONE -> IDLE unconditionally after one cycle.
- Accept:
  - Occurs when cmd_valid & cmd_ready at a rising edge.
  - cmd_ready=1 only in IDLE.
  - On accept: mode and pattern are latched, prescaler=0, bit_cnt=0, phase=0.
  - Command inputs are ignored outside IDLE.
- Prescaler:
  - In RUN, increments every cycle.
  - Wraps to 0 after the cycle in which it equals TICK_DIV-1.
  - step = (state==RUN) & (prescaler==TICK_DIV-1) & ~stop.
  - First step occurs TICK_DIV cycles after the accept edge; subsequent steps are every TICK_DIV cycles.
- bit_cnt advances on each step and wraps BITS-1 -> 0.
- d derivation (combinational from registered state):
  - Mode 00: d=1 iff bit_cnt==0. Repeats indefinitely.
  - Mode 01: d=~phase. phase toggles when bit_cnt wraps, giving BITS ones then BITS zeros, repeating indefinitely.
  - Mode 10: d=pat[BITS-1-bit_cnt]. The step with bit_cnt==BITS-1 is the last; the next state is DONE.
  - Outside RUN: d=0.
- busy=1 in RUN only.
- done=1 for exactly the one cycle spent in DONE.
- done is not asserted on stop.
- stop:
  - Sampled in RUN only; ignored in IDLE and DONE.
  - Masks step in the same cycle.
  - Next state is IDLE; counters are left unchanged and cleared at the next accept.
- rst mid-command returns to IDLE on that edge with no further steps; rst has priority over everything.
- A command may be accepted on the cycle after DONE, when cmd_ready returns to 1.

Optional Feature:
- Macro SHIFT_PATTERN_CTRL_PAUSE_EN.
- When defined:
  - Adds input port pause (1 bit).
  - While pause=1 in RUN: prescaler, bit_cnt and phase hold, and step is forced to 0.
  - Release resumes the count exactly where it stopped.
  - stop overrides pause.
- When undefined: no pause port, and the behaviour is as above.

Test Plan:
- BITS=8, TICK_DIV=4; reset, then mode 10 with pat=8'hA5 -> 8 step pulses at accept+4, +8, …, +32 cycles; d sequence 1,0,1,0,0,1,0,1; done high 1 cycle after the 8th step; cmd_ready back high the following cycle.
- Mode 00, run 20 steps -> d=1 on steps 1, 9 and 17 only; busy stays 1; done never asserted.
- Mode 01, run 16 steps -> d=1 for steps 1–8 and 0 for steps 9–16; step 17 has d=1.
- Mode 00, assert stop in the cycle where prescaler=3 -> no step that cycle; busy=0 next cycle; done stays 0; cmd_valid held high is accepted the cycle after.
- Mode 11 -> no steps; done pulses the cycle after accept. cmd_valid asserted while busy -> no accept (cmd_ready=0), and the running mode is unaffected.
- rst asserted mid mode 10 after 3 steps -> next cycle busy=0, step=0, d=0, cmd_ready=1; new mode 10 restarts from pat MSB. With the pause macro defined, pause for 10 cycles in mid-run -> step gap lengthens by exactly 10 cycles.

Source files
------------

// File: rtl/shift_pattern_ctrl.sv
// Sequencer for a BITS-wide LED shift register: walk-one, fill/drain and one-shot pattern modes.
// Optional pause input is enabled by defining SHIFT_PATTERN_CTRL_PAUSE_EN.
module shift_pattern_ctrl #(
   parameter int BITS     = 8,
   parameter int TICK_DIV = 50000000,
   parameter int DIV_W    = 26
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_mode,
   input  logic [BITS-1:0] cmd_pat,
   input  logic            stop,
`ifdef SHIFT_PATTERN_CTRL_PAUSE_EN
   input  logic            pause,
`endif
   output logic            step,
   output logic            d,
   output logic            busy,
   output logic            done
);

   localparam int CNT_W = $clog2(BITS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {
      M_WALK = 2'b00,
      M_FILL = 2'b01,
      M_PAT  = 2'b10,
      M_NOP  = 2'b11
   } mode_t;

   state_t            state, state_nx;
   mode_t             mode_q;
   logic [BITS-1:0]   pat_q;
   logic [DIV_W-1:0]  presc;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  pat_idx;
   logic              phase;
   logic              hold;
   logic              tick_end;
   logic              last_bit;
   logic              accept;
   logic              advance;

`ifdef SHIFT_PATTERN_CTRL_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   assign tick_end = (presc == DIV_W'(TICK_DIV - 1));
   assign last_bit = (bit_cnt == CNT_W'(BITS - 1));
   assign pat_idx  = CNT_W'(BITS - 1) - bit_cnt;
   assign accept   = (state == IDLE) && cmd_valid;
   // stop takes precedence over pause: counters freeze either way, but only stop leaves RUN
   assign advance  = (state == RUN) && !stop && !hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mode_q  <= M_WALK;
         pat_q   <= '0;
         presc   <= '0;
         bit_cnt <= '0;
         phase   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            mode_q  <= mode_t'(cmd_mode);
            pat_q   <= cmd_pat;
            presc   <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
         end else if (advance) begin
            if (tick_end) begin
               presc <= '0;
               if (last_bit) begin
                  bit_cnt <= '0;
                  phase   <= ~phase;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      step      = 1'b0;
      d         = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_nx = (cmd_mode == 2'b11) ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            case (mode_q)
               M_WALK:  d = (bit_cnt == '0);
               M_FILL:  d = ~phase;
               M_PAT:   d = pat_q[pat_idx];
               default: d = 1'b0;
            endcase
            if (stop) begin
               state_nx = IDLE;
            end else if (!hold && tick_end) begin
               step = 1'b1;
               if (mode_q == M_PAT && last_bit)
                  state_nx = DONE;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_pattern_ctrl.sv
// Scoreboard bench for shift_pattern_ctrl (BITS=8, TICK_DIV=4): table of commands plus hand sequences.
module tb_shift_pattern_ctrl;
   localparam int BITS = 8;
   localparam int TD   = 4;

   logic            clk = 1'b0;
   logic            rst, cmd_valid, cmd_ready, stop, step, d, busy, done;
   logic [1:0]      cmd_mode;
   logic [BITS-1:0] cmd_pat;
`ifdef SHIFT_PATTERN_CTRL_PAUSE_EN
   logic            pause;
`endif

   shift_pattern_ctrl #(.BITS(BITS), .TICK_DIV(TD), .DIV_W(3)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_pat(cmd_pat), .stop(stop),
`ifdef SHIFT_PATTERN_CTRL_PAUSE_EN
      .pause(pause),
`endif
      .step(step), .d(d), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]      mode;
      logic [BITS-1:0] pat;
      int              nsteps;
      bit              exp_done;
   } vec_t;

   int checks = 0, errors = 0;
   int cyc = 0, phase_ref = 0, step_cnt = 0, done_cnt = 0;
   bit exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit model_d(input logic [1:0] mode, input logic [BITS-1:0] pat, input int i);
      case (mode)
         2'b00:   return (i % BITS) == 0;
         2'b01:   return ((i / BITS) % 2) == 0;
         2'b10:   return pat[BITS-1-i];
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) cyc++;

   // Scoreboard: every step pops one expected serial bit and must fall on the prescaler phase
   always @(negedge clk) begin
      if (step) begin
         step_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_step", 1, 0);
         end else begin
            bit e;
            e = exp_q.pop_front();
            chk("step_d", int'(d), int'(e));
         end
         chk("step_phase", (cyc - phase_ref) % TD, TD - 1);
      end
      if (done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] mode, input logic [BITS-1:0] pat, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(model_d(mode, pat, i));
   endtask

   task automatic send_cmd(input logic [1:0] mode, input logic [BITS-1:0] pat);
      cmd_valid = 1'b1;
      cmd_mode  = mode;
      cmd_pat   = pat;
      chk("cmd_ready_idle", int'(cmd_ready), 1);
      tick();
      cmd_valid = 1'b0;
      phase_ref = cyc;
   endtask

   task automatic wait_steps(input int n);
      int target, budget;
      target = step_cnt + n;
      budget = n * TD + 8;
      while (step_cnt < target && budget > 0) begin
         tick();
         budget--;
      end
      chk("step_count", step_cnt, target);
   endtask

   task automatic stop_at_tick_end();
      while ((cyc - phase_ref) % TD != TD - 1) tick();
      stop = 1'b1;
      #1;
      chk("stop_masks_step", int'(step), 0);
      chk("stop_busy_before", int'(busy), 1);
      tick();
      stop = 1'b0;
      chk("stop_busy_after", int'(busy), 0);
      chk("stop_ready_after", int'(cmd_ready), 1);
      chk("stop_no_done", int'(done), 0);
   endtask

   vec_t vecs[5];

   initial begin
      int base;
      vecs[0] = '{mode: 2'b10, pat: 8'hA5, nsteps: 8,  exp_done: 1'b1};
      vecs[1] = '{mode: 2'b00, pat: 8'h00, nsteps: 20, exp_done: 1'b0};
      vecs[2] = '{mode: 2'b01, pat: 8'h00, nsteps: 17, exp_done: 1'b0};
      vecs[3] = '{mode: 2'b10, pat: 8'h3C, nsteps: 8,  exp_done: 1'b1};
      vecs[4] = '{mode: 2'b11, pat: 8'hFF, nsteps: 0,  exp_done: 1'b1};

      rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_pat = '0; stop = 1'b0;
`ifdef SHIFT_PATTERN_CTRL_PAUSE_EN
      pause = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_step", int'(step), 0);
      chk("rst_d", int'(d), 0);
      rst = 1'b0;
      tick();

      foreach (vecs[k]) begin
         base = done_cnt;
         push_exp(vecs[k].mode, vecs[k].pat, vecs[k].nsteps);
         send_cmd(vecs[k].mode, vecs[k].pat);
         if (vecs[k].mode == 2'b11) begin
            chk("nop_done", int'(done), 1);
            chk("nop_busy", int'(busy), 0);
            tick();
            chk("nop_ready", int'(cmd_ready), 1);
         end else begin
            wait_steps(vecs[k].nsteps);
            if (vecs[k].exp_done) begin
               chk("pat_done", int'(done), 1);
               chk("pat_busy", int'(busy), 0);
               chk("pat_ready_in_done", int'(cmd_ready), 0);
               tick();
               chk("pat_ready_after", int'(cmd_ready), 1);
               chk("pat_done_one_cycle", int'(done), 0);
            end else begin
               chk("run_busy", int'(busy), 1);
               chk("run_no_done", done_cnt - base, 0);
               stop_at_tick_end();
            end
         end
         tick();
      end

      // Command offered while running is ignored, then accepted once stop returns to IDLE
      push_exp(2'b00, '0, 2);
      send_cmd(2'b00, '0);
      wait_steps(2);
      cmd_valid = 1'b1; cmd_mode = 2'b11;
      tick();
      chk("busy_ready_low", int'(cmd_ready), 0);
      chk("busy_unaffected", int'(busy), 1);
      base = done_cnt;
      stop_at_tick_end();
      tick();
      cmd_valid = 1'b0;
      chk("held_cmd_done", int'(done), 1);
      tick();
      chk("held_done_count", done_cnt - base, 1);

      // Reset mid pattern, then a fresh pattern restarts at the MSB
      push_exp(2'b10, 8'hC3, 3);
      send_cmd(2'b10, 8'hC3);
      wait_steps(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_step", int'(step), 0);
      chk("midrst_d", int'(d), 0);
      chk("midrst_ready", int'(cmd_ready), 1);
      push_exp(2'b10, 8'h96, 8);
      send_cmd(2'b10, 8'h96);
      wait_steps(8);
      chk("restart_done", int'(done), 1);
      tick();

`ifdef SHIFT_PATTERN_CTRL_PAUSE_EN
      push_exp(2'b10, 8'h5A, 8);
      send_cmd(2'b10, 8'h5A);
      wait_steps(3);
      pause = 1'b1;
      repeat (10) tick();
      pause = 1'b0;
      phase_ref = phase_ref + 10;
      wait_steps(5);
      chk("pause_done", int'(done), 1);
      tick();
`endif

      repeat (TD * 2) tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end
endmodule
